alu_issue_stage: RTL

Operand-issue and write-back stage that sits directly around the combinational ALU. It holds the 4-entry 16-bit architectural register file, accepts one decoded operation at a time over a valid/ready handshake, and drives `func`/`data_1`/`data_2` into the ALU for one execute cycle. It then captures the ALU result, writes it to the destination register and presents it downstream over a second valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Operand-issue / write-back stage wrapped around a combinational
//             ALU. Holds a small architectural register file, accepts one
//             decoded operation at a time, drives the ALU for one execute
//             cycle, writes the result back and offers it downstream.
//  Ports    : clk, reset           - clock, async active-high reset
//             in_valid/in_ready    - upstream operation handshake
//             in_func/rs/rt/rd     - decoded operation fields
//             in_imm_sel/in_imm    - immediate select and value for operand 2
//             alu_func/data_1/2    - registered drive into the ALU
//             alu_result           - combinational ALU result
//             out_valid/out_ready  - downstream result handshake
//             out_result/rd/zero   - captured result, destination, zero flag
//             dbg_addr/dbg_data    - combinational register file read port
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
   parameter int WORD_SIZE = 16,
   parameter int NUM_REGS  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_func,
   input  logic [1:0]           in_rs,
   input  logic [1:0]           in_rt,
   input  logic [1:0]           in_rd,
   input  logic                 in_imm_sel,
   input  logic [WORD_SIZE-1:0] in_imm,
   output logic [2:0]           alu_func,
   output logic [WORD_SIZE-1:0] alu_data_1,
   output logic [WORD_SIZE-1:0] alu_data_2,
   input  logic [WORD_SIZE-1:0] alu_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_result,
   output logic [1:0]           out_rd,
   output logic                 out_zero,
   input  logic [1:0]           dbg_addr,
   output logic [WORD_SIZE-1:0] dbg_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic                 w_in_ready;
   logic                 w_out_valid;
   logic                 w_accept;
   logic                 w_exec;

   logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
   logic [2:0]           r_func;
   logic [WORD_SIZE-1:0] r_op1;
   logic [WORD_SIZE-1:0] r_op2;
   logic [1:0]           r_rd;
   logic [WORD_SIZE-1:0] r_out_result;
   logic [1:0]           r_out_rd;
   logic                 r_out_zero;

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            w_next_state = S_RESP;
         end
         S_RESP: begin
            w_out_valid = 1'b1;
            // Returning to IDLE first guarantees no accept on the
            // handshake cycle and that write-back precedes the next read.
            if (out_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   assign w_accept = w_in_ready & in_valid;
   assign w_exec   = (r_state == S_EXEC);

   // ------------------------------------------------------------------------
   // Operand latch: sampled at accept, so rd == rs/rt reads the old value.
   // These registers are the ALU drive and hold between operations.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_func <= '0;
         r_op1  <= '0;
         r_op2  <= '0;
         r_rd   <= '0;
      end else if (w_accept) begin
         r_func <= in_func;
         r_op1  <= r_regs[in_rs];
         r_op2  <= in_imm_sel ? in_imm : r_regs[in_rt];
         r_rd   <= in_rd;
      end
   end

   // ------------------------------------------------------------------------
   // Result capture and register write-back on the edge leaving EXEC
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_result <= '0;
         r_out_rd     <= '0;
         r_out_zero   <= 1'b1;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_exec) begin
         r_out_result <= alu_result;
         r_out_rd     <= r_rd;
         r_out_zero   <= (alu_result == '0);
         r_regs[r_rd] <= alu_result;
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = w_out_valid;
   assign alu_func   = r_func;
   assign alu_data_1 = r_op1;
   assign alu_data_2 = r_op2;
   assign out_result = r_out_result;
   assign out_rd     = r_out_rd;
   assign out_zero   = r_out_zero;
   assign dbg_data   = r_regs[dbg_addr];

endmodule
`default_nettype wire
